phase_snap_ctrl: RTL and testbench
==================================

Name: phase_snap_ctrl

Overview:
- Capture controller for the channelizer phase snapshot.
- Once armed and triggered, writes a run-time-programmed number of phase samples into the snapshot BRAM.
- Publishes a live status word (done/busy flags plus the current write count) to the snapPhase_addr software-readable register via that register's user_data_in.
- Runs entirely in the user_clk domain; the register block handles the crossing to OPB.

Parameters:
- ADDR_WIDTH, 10, BRAM address width; maximum capture length is 2^ADDR_WIDTH samples.
- DATA_WIDTH, 32, phase sample width written to BRAM.

Ports:
- user_clk  in  1  capture clock (DSP clock).
- user_rst_n  in  1  asynchronous, active-low reset.
- arm  in  1  single-cycle pulse; clears count and enters ARMED.
- trig  in  1  capture start qualifier; level-sampled.
- snap_len  in  ADDR_WIDTH+1  samples per capture; 0 means 2^ADDR_WIDTH; sampled on arm.
- din_valid  in  1  phase sample strobe.
- din  in  DATA_WIDTH  phase sample.
- bram_we  out  1  BRAM write enable.
- bram_addr  out  ADDR_WIDTH  BRAM write address.
- bram_din  out  DATA_WIDTH  BRAM write data.
- busy  out  1  high in ARMED or CAPTURE.
- done  out  1  high in DONE.
- status  out  32  to snapPhase_addr user_data_in: bit31=done, bit30=busy, bits[ADDR_WIDTH:0]=samples written, other bits 0.

Behaviour:
- Reset (async assert, sync release): state IDLE; bram_we=0, bram_addr=0, bram_din=0, busy=0, done=0, status=0, count=0, len_reg=0.
- All outputs are registered.
- State machine (IDLE, ARMED, CAPTURE, DONE):
  - IDLE: arm -> ARMED.
  - ARMED: trig=1 and din_valid=1 in the same cycle -> that sample is written at address 0 and the state moves to CAPTURE. trig without din_valid does not start a capture.
  - CAPTURE: every din_valid writes din at address count; trig is ignored. When the write reaches address len_reg-1 -> DONE on the same edge.
  - DONE: holds. arm -> ARMED.
- arm in ANY state (including ARMED or CAPTURE) restarts: count=0, len_reg<=snap_len (0 maps to 2^ADDR_WIDTH), state ARMED, and bram_we=0 that cycle. arm has priority over a simultaneous trig or din_valid; that sample is dropped.
- Write path latency is 1 cycle: the accepted sample at edge N gives bram_we=1, bram_addr=count, bram_din=din registered after edge N. count increments on the same edge.
- bram_we is 0 in every cycle with no accepted sample. There are no writes in IDLE or DONE.
- status[ADDR_WIDTH:0] equals the number of samples written and updates on the same edge as bram_we. After a full capture it equals len_reg (e.g. 1024 for len 0, so the field is ADDR_WIDTH+1 bits wide).
- Addresses never wrap: the capture stops at len_reg and DONE is the terminal state. Extra din_valid after DONE is ignored.
- len_reg is latched at arm; changes to snap_len mid-capture have no effect.
- Reset mid-capture aborts immediately to the reset values. The BRAM contents are not cleared.
- Flags:
  - busy=1 exactly in ARMED/CAPTURE; done=1 exactly in DONE; never both high.
  - status[31]=done and status[30]=busy, with the same timing as the flags.

Test Plan:
- Reset then idle with din_valid toggling -> bram_we never 1; status=0x00000000; busy=0, done=0.
- snap_len=4, arm, then trig+valid with din=0xA0, followed by valid samples 0xA1, 0xA2, 0xA3 -> four writes at addresses 0..3 with data A0..A3. status then reads 0x80000004, done=1, busy=0, and further valids produce no writes.
- snap_len=0, arm, trig, valid every cycle for 1100 cycles -> exactly 1024 writes at addresses 0..1023, then status=0x80000400.
- Armed, trig=1 with din_valid=0 for 5 cycles, then din_valid=1 with trig=0 -> no writes; state stays ARMED and status=0x40000000.
- snap_len=8, capture 3 samples, then assert arm simultaneously with din_valid -> that sample is not written. status=0x40000000; a new trig restarts writing at address 0.
- snap_len=8, drop user_rst_n after 5 writes -> all outputs 0 asynchronously; after release, state is IDLE and status=0.

Source files
------------

// File: rtl/phase_snap_ctrl.sv
// Phase snapshot capture controller: arm/trigger sequencing into BRAM
// and live done/busy/count status for the software register.
module phase_snap_ctrl #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  user_clk,
    input  logic                  user_rst_n,
    input  logic                  arm,
    input  logic                  trig,
    input  logic [ADDR_WIDTH:0]   snap_len,
    input  logic                  din_valid,
    input  logic [DATA_WIDTH-1:0] din,
    output logic                  bram_we,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic [DATA_WIDTH-1:0] bram_din,
    output logic                  busy,
    output logic                  done,
    output logic [31:0]           status
);

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        CAPTURE,
        DONE
    } state_t;

    localparam logic [ADDR_WIDTH:0] FULL_LEN =
        {1'b1, {ADDR_WIDTH{1'b0}}};

    state_t              state;
    logic [ADDR_WIDTH:0] count;
    logic [ADDR_WIDTH:0] len_reg;
    logic [ADDR_WIDTH:0] cnt_inc;
    logic [ADDR_WIDTH:0] len_sel;
    logic                accept;

    assign cnt_inc = count + 1'b1;
    assign len_sel = (snap_len == '0) ? FULL_LEN : snap_len;

    // ARMED only starts on trig qualified by a valid sample
    assign accept = ((state == ARMED) && trig && din_valid) ||
                    ((state == CAPTURE) && din_valid);

    function automatic logic [31:0] status_word(
        input logic                d,
        input logic                b,
        input logic [ADDR_WIDTH:0] c
    );
        logic [31:0] s;
        s = '0;
        s[31] = d;
        s[30] = b;
        s[ADDR_WIDTH:0] = c;
        return s;
    endfunction

    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            state     <= IDLE;
            count     <= '0;
            len_reg   <= '0;
            bram_we   <= 1'b0;
            bram_addr <= '0;
            bram_din  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            status    <= '0;
        end else begin
            bram_we <= 1'b0;
            if (arm) begin
                state   <= ARMED;
                count   <= '0;
                len_reg <= len_sel;
                busy    <= 1'b1;
                done    <= 1'b0;
                status  <= status_word(1'b0, 1'b1, '0);
            end else if (accept) begin
                bram_we   <= 1'b1;
                bram_addr <= count[ADDR_WIDTH-1:0];
                bram_din  <= din;
                count     <= cnt_inc;
                if (cnt_inc == len_reg) begin
                    state  <= DONE;
                    busy   <= 1'b0;
                    done   <= 1'b1;
                    status <= status_word(1'b1, 1'b0, cnt_inc);
                end else begin
                    state  <= CAPTURE;
                    status <= status_word(1'b0, 1'b1, cnt_inc);
                end
            end
        end
    end

endmodule

// File: tb/tb_phase_snap_ctrl.sv
// Directed bench for phase_snap_ctrl: capture lengths, trigger
// qualification, arm restart and asynchronous reset abort.
module tb_phase_snap_ctrl;

    logic        user_clk;
    logic        user_rst_n;
    logic        arm;
    logic        trig;
    logic [10:0] snap_len;
    logic        din_valid;
    logic [31:0] din;
    logic        bram_we;
    logic [9:0]  bram_addr;
    logic [31:0] bram_din;
    logic        busy;
    logic        done;
    logic [31:0] status;

    int checks;
    int errors;

    phase_snap_ctrl #(
        .ADDR_WIDTH(10),
        .DATA_WIDTH(32)
    ) dut (
        .user_clk  (user_clk),
        .user_rst_n(user_rst_n),
        .arm       (arm),
        .trig      (trig),
        .snap_len  (snap_len),
        .din_valid (din_valid),
        .din       (din),
        .bram_we   (bram_we),
        .bram_addr (bram_addr),
        .bram_din  (bram_din),
        .busy      (busy),
        .done      (done),
        .status    (status)
    );

    initial begin
        user_clk = 1'b0;
        forever #5 user_clk = ~user_clk;
    end

    task automatic tick();
        @(posedge user_clk);
        #1;
    endtask

    task automatic do_arm(input logic [10:0] len);
        snap_len  = len;
        arm       = 1'b1;
        trig      = 1'b0;
        din_valid = 1'b0;
        tick();
        arm = 1'b0;
    endtask

    task automatic test_reset();
        user_rst_n = 1'b0;
        arm = 1'b0;
        trig = 1'b0;
        snap_len = '0;
        din_valid = 1'b0;
        din = '0;
        #12;
        checks++;
        if ({bram_we, bram_addr, bram_din, busy, done, status} !== '0) begin
            errors++;
            $display("FAIL reset_outs: we=%b addr=%h din=%h busy=%b done=%b status=%h, want all 0",
                     bram_we, bram_addr, bram_din, busy, done, status);
        end
        user_rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            din_valid = i[0];
            trig = 1'b1;
            din = 32'h1234_0000 + i;
            tick();
            checks++;
            if (bram_we !== 1'b0 || status !== 32'h0 || busy !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("FAIL idle_%0d: we=%b status=%h busy=%b done=%b, want 0/0/0/0",
                         i, bram_we, status, busy, done);
            end
        end
        trig = 1'b0;
        din_valid = 1'b0;
    endtask

    task automatic test_basic_capture();
        logic [31:0] exp_st;
        do_arm(11'd4);
        checks++;
        if (status !== 32'h4000_0000 || busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL basic_armed: status=%h busy=%b done=%b, want 40000000/1/0",
                     status, busy, done);
        end
        for (int i = 0; i < 4; i++) begin
            trig = (i == 0);
            din_valid = 1'b1;
            din = 32'hA0 + i;
            tick();
            exp_st = (i == 3) ? 32'h8000_0004 : (32'h4000_0000 + i + 1);
            checks++;
            if (bram_we !== 1'b1 || bram_addr !== 10'(i) ||
                bram_din !== 32'hA0 + i || status !== exp_st) begin
                errors++;
                $display("FAIL basic_wr_%0d: we=%b addr=%0d din=%h status=%h, want 1/%0d/%h/%h",
                         i, bram_we, bram_addr, bram_din, status, i, 32'hA0 + i, exp_st);
            end
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_flags: done=%b busy=%b, want 1/0", done, busy);
        end
        for (int i = 0; i < 3; i++) begin
            trig = 1'b1;
            din = 32'hEE;
            tick();
            checks++;
            if (bram_we !== 1'b0 || status !== 32'h8000_0004) begin
                errors++;
                $display("FAIL basic_post_%0d: we=%b status=%h, want 0/80000004",
                         i, bram_we, status);
            end
        end
        trig = 1'b0;
        din_valid = 1'b0;
    endtask

    task automatic test_full_length();
        int writes;
        int bad;
        writes = 0;
        bad = 0;
        do_arm(11'd0);
        trig = 1'b1;
        din_valid = 1'b1;
        for (int i = 0; i < 1100; i++) begin
            din = 32'h5000_0000 + i;
            tick();
            if (bram_we === 1'b1) begin
                if (bram_addr !== 10'(writes) || bram_din !== 32'h5000_0000 + writes)
                    bad++;
                writes++;
            end
        end
        checks++;
        if (writes != 1024 || bad != 0) begin
            errors++;
            $display("FAIL full_writes: count=%0d bad_addr_or_data=%0d, want 1024/0",
                     writes, bad);
        end
        checks++;
        if (status !== 32'h8000_0400 || done !== 1'b1) begin
            errors++;
            $display("FAIL full_status: status=%h done=%b, want 80000400/1", status, done);
        end
        trig = 1'b0;
        din_valid = 1'b0;
    endtask

    task automatic test_trig_no_valid();
        int wr;
        wr = 0;
        do_arm(11'd8);
        trig = 1'b1;
        din_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bram_we !== 1'b0) wr++;
        end
        trig = 1'b0;
        din_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (bram_we !== 1'b0) wr++;
        end
        checks++;
        if (wr != 0) begin
            errors++;
            $display("FAIL trig_novalid_writes: writes=%0d, want 0", wr);
        end
        checks++;
        if (status !== 32'h4000_0000 || busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL trig_novalid_status: status=%h busy=%b done=%b, want 40000000/1/0",
                     status, busy, done);
        end
        din_valid = 1'b0;
    endtask

    task automatic test_arm_restart();
        do_arm(11'd8);
        snap_len = 11'd2;
        for (int i = 0; i < 3; i++) begin
            trig = (i == 0);
            din_valid = 1'b1;
            din = 32'hB0 + i;
            tick();
        end
        checks++;
        if (status !== 32'h4000_0003 || bram_addr !== 10'd2) begin
            errors++;
            $display("FAIL restart_pre: status=%h addr=%0d, want 40000003/2",
                     status, bram_addr);
        end
        arm = 1'b1;
        trig = 1'b1;
        din_valid = 1'b1;
        din = 32'hBF;
        snap_len = 11'd8;
        tick();
        arm = 1'b0;
        checks++;
        if (bram_we !== 1'b0 || status !== 32'h4000_0000) begin
            errors++;
            $display("FAIL restart_arm: we=%b status=%h, want 0/40000000",
                     bram_we, status);
        end
        trig = 1'b0;
        din_valid = 1'b0;
        tick();
        trig = 1'b1;
        din_valid = 1'b1;
        din = 32'hC0;
        tick();
        checks++;
        if (bram_we !== 1'b1 || bram_addr !== 10'd0 ||
            bram_din !== 32'hC0 || status !== 32'h4000_0001) begin
            errors++;
            $display("FAIL restart_first: we=%b addr=%0d din=%h status=%h, want 1/0/c0/40000001",
                     bram_we, bram_addr, bram_din, status);
        end
        trig = 1'b0;
        din_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_arm(11'd8);
        for (int i = 0; i < 5; i++) begin
            trig = (i == 0);
            din_valid = 1'b1;
            din = 32'hD0 + i;
            tick();
        end
        checks++;
        if (status !== 32'h4000_0005 || bram_we !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_pre: status=%h we=%b, want 40000005/1", status, bram_we);
        end
        #2;
        user_rst_n = 1'b0;
        #1;
        checks++;
        if ({bram_we, bram_addr, bram_din, busy, done, status} !== '0) begin
            errors++;
            $display("FAIL rstmid_async: we=%b addr=%h din=%h busy=%b done=%b status=%h, want all 0",
                     bram_we, bram_addr, bram_din, busy, done, status);
        end
        #3;
        user_rst_n = 1'b1;
        trig = 1'b1;
        din_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (bram_we !== 1'b0 || status !== 32'h0 || busy !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("FAIL rstmid_idle_%0d: we=%b status=%h busy=%b done=%b, want 0/0/0/0",
                         i, bram_we, status, busy, done);
            end
        end
        trig = 1'b0;
        din_valid = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic_capture();
        test_full_length();
        test_trig_no_valid();
        test_arm_restart();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
